// File: rtl/rvvi_frame_packer_if.sv
// rtl/rvvi_frame_packer_if.sv - beat stream link from the frame packer to the trace transport
interface rvvi_frame_packer_if;
    logic        OutValid;
    logic        OutReady;
    logic [63:0] OutData;
    logic        OutLast;

    modport master (
        output OutValid,
        output OutData,
        output OutLast,
        input  OutReady
    );

    modport slave (
        input  OutValid,
        input  OutData,
        input  OutLast,
        output OutReady
    );
endinterface

// File: rtl/rvvi_frame_packer.sv
// rtl/rvvi_frame_packer.sv - buffers flat RVVI frames and drains them as variable-length 64-bit beat streams
//
// Input frame layout, LSB first (XLEN <= 64):
//   PC, Mcycle, Minstret (XLEN each)
//   L3 64b: [1:0] Priv, [2] Trap, [15:8] CSRCount, [63:32] Instr
//   L4 64b: [4:0] register address, [8] GPRWen, [9] FPRWen
//   RegVal (XLEN), MAX_CSRS CSR values (XLEN each), MAX_CSRS CSR addresses (16b each)
module rvvi_frame_packer #(
    parameter int XLEN        = 64,
    parameter int MAX_CSRS    = 5,
    parameter int DEPTH       = 4,
    parameter int HALT_THRESH = 3,
    parameter int RVVI_WIDTH  = 128 + 4*XLEN + MAX_CSRS*(XLEN+16)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     Enable,
    input  logic                     InValid,
    input  logic [RVVI_WIDTH-1:0]    InRvvi,
    rvvi_frame_packer_if.master      tx,
    output logic                     HaltReq,
    output logic                     Overflow,
    output logic [15:0]              DropCount,
    output logic [$clog2(DEPTH):0]   Occupancy
);
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int OFF_MCYC  = XLEN;
    localparam int OFF_MINST = 2*XLEN;
    localparam int OFF_L3    = 3*XLEN;
    localparam int OFF_L4    = 3*XLEN + 64;
    localparam int OFF_REG   = 3*XLEN + 128;
    localparam int OFF_VAL   = 4*XLEN + 128;
    localparam int OFF_ADDR  = 4*XLEN + 128 + MAX_CSRS*XLEN;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t state, state_next;
    logic [7:0] beat_idx, beat_next;

    logic [RVVI_WIDTH-1:0] mem_frame [DEPTH];
    logic [15:0]           mem_seq   [DEPTH];
    logic                  mem_dp    [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [15:0]   seq;
    logic          drop_pend;

    logic [RVVI_WIDTH-1:0] head;
    logic [63:0] l3, l4;
    logic [7:0]  csr_cnt, n_csr, n_lanes, beats, val_base, addr_base;
    logic        has_reg;
    logic [63:0] beat_data;
    logic        last_beat, handshake, pop, push, drop, full, push_req;

    // Head entry decode: the frame at the FIFO head defines the current stream length
    assign head      = mem_frame[rd_ptr];
    assign l3        = head[OFF_L3 +: 64];
    assign l4        = head[OFF_L4 +: 64];
    assign csr_cnt   = l3[15:8];
    assign has_reg   = l4[8] | l4[9];
    assign n_csr     = (csr_cnt > 8'(MAX_CSRS)) ? 8'(MAX_CSRS) : csr_cnt;
    assign n_lanes   = (n_csr + 8'd3) >> 2;
    assign val_base  = 8'd6 + {7'd0, has_reg};
    assign addr_base = val_base + n_csr;
    assign beats     = addr_base + n_lanes;

    // Beat multiplexer: selects the lane for the current beat index, zero-extended to 64 bits
    always_comb begin
        beat_data = '0;
        if (beat_idx == 8'd0) begin
            beat_data = {16'h0, mem_seq[rd_ptr], 6'd0, mem_dp[rd_ptr], has_reg, beats, 16'h5256};
        end else if (beat_idx < 8'd6) begin
            case (beat_idx)
                8'd1:    beat_data = 64'(head[0 +: XLEN]);
                8'd2:    beat_data = 64'(head[OFF_MCYC +: XLEN]);
                8'd3:    beat_data = 64'(head[OFF_MINST +: XLEN]);
                8'd4:    beat_data = l3;
                default: beat_data = l4;
            endcase
        end else if (beat_idx < val_base) begin
            beat_data = 64'(head[OFF_REG +: XLEN]);
        end else if (beat_idx < addr_base) begin
            for (int j = 0; j < MAX_CSRS; j++) begin
                if ((beat_idx - val_base) == 8'(j))
                    beat_data = 64'(head[OFF_VAL + j*XLEN +: XLEN]);
            end
        end else begin
            // Four addresses per lane; slots at or beyond N stay zero
            for (int j = 0; j < MAX_CSRS; j++) begin
                if (((beat_idx - addr_base) == 8'(j/4)) && (8'(j) < n_csr))
                    beat_data[(j%4)*16 +: 16] = head[OFF_ADDR + 16*j +: 16];
            end
        end
    end

    assign last_beat = (beat_idx == beats - 8'd1);
    assign handshake = tx.OutValid & tx.OutReady;
    assign pop       = (state == EMIT) & handshake & last_beat;
    assign full      = (count == CW'(DEPTH));
    assign push_req  = Enable & InValid;
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;
    assign count_next = count + CW'(push) - CW'(pop);

    assign tx.OutValid = (state == EMIT);
    assign tx.OutData  = tx.OutValid ? beat_data : 64'd0;
    assign tx.OutLast  = tx.OutValid & last_beat;
    assign Occupancy   = count;

    // Next-state logic: walk beats on handshakes, chain straight into the next frame when one is queued
    always_comb begin
        state_next = state;
        beat_next  = beat_idx;
        case (state)
            IDLE: begin
                beat_next = 8'd0;
                if (count != '0)
                    state_next = EMIT;
            end
            EMIT: begin
                if (handshake) begin
                    if (last_beat) begin
                        beat_next  = 8'd0;
                        state_next = (count_next != '0) ? EMIT : IDLE;
                    end else begin
                        beat_next = beat_idx + 8'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                beat_next  = 8'd0;
            end
        endcase
    end

    // Control state, FIFO pointers, sequence tagging and drop bookkeeping
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            beat_idx  <= 8'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            seq       <= 16'd0;
            drop_pend <= 1'b0;
            Overflow  <= 1'b0;
            DropCount <= 16'd0;
            HaltReq   <= 1'b0;
        end else begin
            state    <= state_next;
            beat_idx <= beat_next;
            count    <= count_next;
            HaltReq  <= (count_next >= CW'(HALT_THRESH));
            if (push) begin
                wr_ptr    <= wr_ptr + AW'(1);
                seq       <= seq + 16'd1;
                drop_pend <= 1'b0;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (drop) begin
                Overflow  <= 1'b1;
                drop_pend <= 1'b1;
                if (DropCount != 16'hFFFF)
                    DropCount <= DropCount + 16'd1;
            end
        end
    end

    // Frame storage: payload captured together with its sequence tag and pending-drop flag
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem_frame[wr_ptr] <= InRvvi;
            mem_seq[wr_ptr]   <= seq;
            mem_dp[wr_ptr]    <= drop_pend;
        end
    end
endmodule
